// File: rtl/mem_stage_lsu_if.sv
// Data-bus interface of the MEM stage (SRAM-like req/addr_ok/data_ok).
// An address phase transfers in a cycle with req & addr_ok; data_ok returns one response per
// transferred request, strictly in request order.
interface mem_stage_lsu_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM stage with a pipelined load/store unit and an in-order tracking queue of DEPTH entries.
// Optional misaligned-access detection is compiled in with `define MEM_ALIGN_CHK_EN.
// Handshakes: a transfer happens on the cycle where valid & ready are both high; valid never
// waits on ready, and ready may depend combinationally on valid-side inputs (in_ready on addr_ok).
module mem_stage_lsu #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [2:0]      in_ld,
  input  logic [1:0]      in_st,
  input  logic [31:0]     in_addr,
  input  logic [31:0]     in_wdata,
  input  logic [4:0]      in_rd,
  input  logic            in_gr_we,
  mem_stage_lsu_if.master bus,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic            out_gr_we,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_wdata
`ifdef MEM_ALIGN_CHK_EN
  ,
  output logic            out_ale,
  output logic [31:0]     out_badv
`endif
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DISC_W = CNT_W + 4;

  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;
  localparam logic [2:0] LD_W  = 3'd5;
  localparam logic [1:0] ST_B  = 2'd1;
  localparam logic [1:0] ST_H  = 2'd2;

  logic [PC_W-1:0]   q_pc     [DEPTH];
  logic [4:0]        q_rd     [DEPTH];
  logic              q_gr_we  [DEPTH];
  logic [2:0]        q_ld     [DEPTH];
  logic [1:0]        q_lo     [DEPTH];
  logic [31:0]       q_data   [DEPTH];
  logic              q_done   [DEPTH];
  logic              q_issued [DEPTH];
`ifdef MEM_ALIGN_CHK_EN
  logic              q_ale    [DEPTH];
`endif

  logic [PTR_W-1:0]  head, tail, rsp_idx, slot;
  logic [CNT_W-1:0]  count, outstanding;
  logic [DISC_W-1:0] discard, discard_n;
  logic              is_mem, misalign, full, enq, pop, rsp_found, rsp_hit;
  logic              req_c, wr_c;
  logic [1:0]        size_c;
  logic [3:0]        wstrb_c;
  logic [31:0]       wdata_c;

  function automatic logic [31:0] load_ext(input logic [2:0] ld, input logic [1:0] lo,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lo, 3'b000} +: 8];
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (ld)
      LD_B:    load_ext = {{24{b[7]}}, b};
      LD_BU:   load_ext = {24'd0, b};
      LD_H:    load_ext = {{16{h[15]}}, h};
      LD_HU:   load_ext = {16'd0, h};
      LD_W:    load_ext = rd;
      default: load_ext = rd;
    endcase
  endfunction

  // Issue side: request, accept and lane generation for the EX offer.
  always_comb begin
    is_mem = (in_ld != 3'd0) || (in_st != 2'd0);
    if (in_st != 2'd0)                     size_c = in_st - 2'd1;
    else if (in_ld == LD_B || in_ld == LD_BU) size_c = 2'd0;
    else if (in_ld == LD_H || in_ld == LD_HU) size_c = 2'd1;
    else                                    size_c = 2'd2;
`ifdef MEM_ALIGN_CHK_EN
    misalign = is_mem && ((size_c == 2'd1 && in_addr[0]) ||
                          (size_c == 2'd2 && in_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    full     = (count == CNT_W'(DEPTH));
    req_c    = in_valid & is_mem & ~misalign & ~full & ~flush;
    in_ready = ~full & ~flush & (~is_mem | misalign | bus.addr_ok);
    enq      = in_valid & in_ready;
    wr_c     = req_c & (in_st != 2'd0);
    wstrb_c  = 4'b0000;
    wdata_c  = 32'd0;
    if (wr_c) begin
      case (in_st)
        ST_B: begin
          wstrb_c = 4'b0001 << in_addr[1:0];
          wdata_c = {4{in_wdata[7:0]}};
        end
        ST_H: begin
          wstrb_c = in_addr[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{in_wdata[15:0]}};
        end
        default: begin
          wstrb_c = 4'b1111;
          wdata_c = in_wdata;
        end
      endcase
    end
  end

  assign bus.req   = req_c;
  assign bus.wr    = wr_c;
  assign bus.size  = req_c ? size_c : 2'd0;
  assign bus.addr  = req_c ? in_addr : 32'd0;
  assign bus.wstrb = wstrb_c;
  assign bus.wdata = wdata_c;

  // Oldest issued-but-not-done entry receives the next live response.
  always_comb begin
    rsp_found   = 1'b0;
    rsp_idx     = head;
    outstanding = '0;
    slot        = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if (CNT_W'(i) < count && q_issued[slot] && !q_done[slot]) begin
        outstanding = outstanding + CNT_W'(1);
        if (!rsp_found) begin
          rsp_found = 1'b1;
          rsp_idx   = slot;
        end
      end
    end
    rsp_hit = bus.data_ok & (discard == '0) & rsp_found;
  end

  // A response arriving in the flush cycle retires one of the flushed requests.
  always_comb begin
    discard_n = discard;
    if (flush)
      discard_n = discard + DISC_W'(outstanding)
                  - DISC_W'(bus.data_ok && (discard != '0 || outstanding != '0));
    else if (bus.data_ok && discard != '0)
      discard_n = discard - DISC_W'(1);
  end

  assign out_valid = (count != '0) && q_done[head];
  assign pop       = out_valid & out_ready;
  assign out_pc    = out_valid ? q_pc[head] : '0;
  assign out_rd    = out_valid ? q_rd[head] : 5'd0;
  assign out_gr_we = out_valid & q_gr_we[head];
  assign out_wdata = out_valid ? q_data[head] : 32'd0;
`ifdef MEM_ALIGN_CHK_EN
  assign out_ale   = out_valid & q_ale[head];
  assign out_badv  = out_ale ? q_data[head] : 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      discard <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_done[i]   <= 1'b0;
        q_issued[i] <= 1'b0;
      end
    end else begin
      discard <= discard_n;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) begin
          tail           <= tail + PTR_W'(1);
          q_done[tail]   <= ~is_mem | misalign;
          q_issued[tail] <= is_mem & ~misalign;
        end
        if (rsp_hit) q_done[rsp_idx] <= 1'b1;
        if (pop) head <= head + PTR_W'(1);
        count <= count + CNT_W'(enq) - CNT_W'(pop);
      end
    end
  end

  // Payload storage; validity is tracked by count/done, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_pc[tail]    <= in_pc;
      q_rd[tail]    <= in_rd;
      q_gr_we[tail] <= in_gr_we & ~misalign;
      q_ld[tail]    <= in_ld;
      q_lo[tail]    <= in_addr[1:0];
      q_data[tail]  <= in_addr;
`ifdef MEM_ALIGN_CHK_EN
      q_ale[tail]   <= misalign;
`endif
    end
    if (rsp_hit && q_ld[rsp_idx] != 3'd0)
      q_data[rsp_idx] <= load_ext(q_ld[rsp_idx], q_lo[rsp_idx], bus.rdata);
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: scoreboard of expected WB retirements plus bus/latency checks.
module tb_mem_stage_lsu;
  localparam int EW = 70;  // {pc[31:0], rd[4:0], gr_we, wdata[31:0]}

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_gr_we;
  logic [31:0] in_pc, in_addr, in_wdata;
  logic [2:0]  in_ld;
  logic [1:0]  in_st;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_gr_we;
  logic [31:0] out_pc, out_wdata;
  logic [4:0]  out_rd;
`ifdef MEM_ALIGN_CHK_EN
  logic        out_ale;
  logic [31:0] out_badv;
`endif

  mem_stage_lsu_if bus();

  mem_stage_lsu #(.DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ld(in_ld), .in_st(in_st),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd), .in_gr_we(in_gr_we),
    .bus(bus),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_gr_we(out_gr_we),
    .out_rd(out_rd), .out_wdata(out_wdata)
`ifdef MEM_ALIGN_CHK_EN
    , .out_ale(out_ale), .out_badv(out_badv)
`endif
  );

  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e, obs_e;
  int n_checks = 0, n_errors = 0, n_pops = 0, n_pushed = 0;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                          input logic [31:0] wd);
    exp_q.push_back({pc, rd, we, we ? wd : 32'd0});
    n_pushed++;
  endtask

  // exp_bus = {wr, size, wstrb, addr}; bus ready is offered immediately for mem ops
  task automatic send(input logic [31:0] pc, input logic [2:0] ld, input logic [1:0] st,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                      input logic we, input logic exp_req, input logic [38:0] exp_bus,
                      input logic [31:0] exp_wdata);
    in_valid = 1'b1; in_pc = pc; in_ld = ld; in_st = st; in_addr = a; in_wdata = wd;
    in_rd = rd; in_gr_we = we;
    bus.addr_ok = (ld != 3'd0) || (st != 2'd0);
    @(negedge clk);
    chk("accept", EW'(in_ready), EW'(1));
    chk("req", EW'(bus.req), EW'(exp_req));
    if (exp_req) chk("bus_ctl", EW'({bus.wr, bus.size, bus.wstrb, bus.addr}), EW'(exp_bus));
    if (exp_req && st != 2'd0) chk("bus_wdata", EW'(bus.wdata), EW'(exp_wdata));
    tick();
    in_valid = 1'b0; in_ld = 3'd0; in_st = 2'd0; bus.addr_ok = 1'b0;
  endtask

  task automatic respond(input logic [31:0] r);
    bus.data_ok = 1'b1;
    bus.rdata   = r;
    tick();
    bus.data_ok = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    chk(tag, EW'(exp_q.size()), EW'(0));
  endtask

  // Scoreboard: every WB handshake must match the oldest expected retirement.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_pops++;
      chk("ret_avail", EW'(exp_q.size() != 0), EW'(1));
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        obs_e = {out_pc, out_rd, out_gr_we, exp_e[32] ? out_wdata : 32'd0};
        chk("retire", obs_e, exp_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_ld = '0; in_st = '0;
    in_addr = '0; in_wdata = '0; in_rd = '0; in_gr_we = 1'b0; out_ready = 1'b1;
    bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.rdata = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out", EW'({out_valid, out_gr_we, out_rd, out_pc}), EW'(0));
    chk("rst_wdata", EW'(out_wdata), EW'(0));
    chk("rst_bus", EW'({bus.req, bus.wr, bus.size, bus.wstrb, bus.addr}), EW'(0));
`ifdef MEM_ALIGN_CHK_EN
    chk("rst_ale", EW'({out_ale, out_badv}), EW'(0));
`endif
    tick();
    rst = 1'b0;
    tick();

    // ld.w 0x100: one cycle of address back-pressure, then data_ok three cycles after issue
    in_valid = 1'b1; in_ld = 3'd5; in_addr = 32'h100; in_pc = 32'h1000;
    in_rd = 5'd1; in_gr_we = 1'b1; bus.addr_ok = 1'b0;
    @(negedge clk);
    chk("hold_req", EW'(bus.req), EW'(1));
    chk("hold_ready", EW'(in_ready), EW'(0));
    tick();
    push_exp(32'h1000, 5'd1, 1'b1, 32'hDEADBEEF);
    send(32'h1000, 3'd5, 2'd0, 32'h100, 32'd0, 5'd1, 1'b1, 1'b1, {1'b0, 2'd2, 4'b0000, 32'h100}, 32'd0);
    tick();
    tick();
    bus.data_ok = 1'b1; bus.rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("lat_pre", EW'(out_valid), EW'(0));
    tick();
    bus.data_ok = 1'b0;
    @(negedge clk);
    chk("lat_load", EW'(out_valid), EW'(1));
    chk("lat_data", EW'(out_wdata), EW'(32'hDEADBEEF));
    tick();

    // byte and half loads with sign/zero extension
    push_exp(32'h2000, 5'd2, 1'b1, 32'hFFFFFF80);
    send(32'h2000, 3'd1, 2'd0, 32'h103, 32'd0, 5'd2, 1'b1, 1'b1, {1'b0, 2'd0, 4'b0000, 32'h103}, 32'd0);
    push_exp(32'h2004, 5'd3, 1'b1, 32'h00000080);
    send(32'h2004, 3'd2, 2'd0, 32'h103, 32'd0, 5'd3, 1'b1, 1'b1, {1'b0, 2'd0, 4'b0000, 32'h103}, 32'd0);
    respond(32'h80FFFF00);
    respond(32'h80FFFF00);
    push_exp(32'h2008, 5'd4, 1'b1, 32'hFFFF8001);
    send(32'h2008, 3'd3, 2'd0, 32'h102, 32'd0, 5'd4, 1'b1, 1'b1, {1'b0, 2'd1, 4'b0000, 32'h102}, 32'd0);
    push_exp(32'h200C, 5'd5, 1'b1, 32'h00001234);
    send(32'h200C, 3'd4, 2'd0, 32'h100, 32'd0, 5'd5, 1'b1, 1'b1, {1'b0, 2'd1, 4'b0000, 32'h100}, 32'd0);
    respond(32'h80011234);
    respond(32'h80011234);
    wait_drain("drain_loads");

    // stores: lanes, replication, size
    push_exp(32'h3000, 5'd0, 1'b0, 32'd0);
    send(32'h3000, 3'd0, 2'd2, 32'h202, 32'h1234ABCD, 5'd0, 1'b0, 1'b1, {1'b1, 2'd1, 4'b1100, 32'h202}, 32'hABCDABCD);
    push_exp(32'h3004, 5'd0, 1'b0, 32'd0);
    send(32'h3004, 3'd0, 2'd1, 32'h201, 32'h000000EF, 5'd0, 1'b0, 1'b1, {1'b1, 2'd0, 4'b0010, 32'h201}, 32'hEFEFEFEF);
    push_exp(32'h3008, 5'd0, 1'b0, 32'd0);
    send(32'h3008, 3'd0, 2'd3, 32'h204, 32'hCAFEF00D, 5'd0, 1'b0, 1'b1, {1'b1, 2'd2, 4'b1111, 32'h204}, 32'hCAFEF00D);
    respond(32'd0);
    respond(32'd0);
    respond(32'd0);
    wait_drain("drain_stores");

    // non-mem pass-through: one-cycle latency, then back-to-back enqueue+pop
    push_exp(32'h4000, 5'd7, 1'b1, 32'h55);
    send(32'h4000, 3'd0, 2'd0, 32'h55, 32'd0, 5'd7, 1'b1, 1'b0, 39'd0, 32'd0);
    @(negedge clk);
    chk("lat_nonmem", EW'(out_valid), EW'(1));
    tick();
    for (int i = 0; i < 3; i++) begin
      push_exp(32'h4004 + 32'(4 * i), 5'(8 + i), 1'b1, 32'h66 + 32'(i));
      send(32'h4004 + 32'(4 * i), 3'd0, 2'd0, 32'h66 + 32'(i), 32'd0, 5'(8 + i), 1'b1, 1'b0, 39'd0, 32'd0);
    end
    wait_drain("drain_nonmem");

    // fill all four entries, fifth offer is refused, responses retire in issue order
    for (int i = 0; i < 4; i++) begin
      push_exp(32'h5000 + 32'(4 * i), 5'(16 + i), 1'b1, 32'hA0000001 + 32'(i));
      send(32'h5000 + 32'(4 * i), 3'd5, 2'd0, 32'h500 + 32'(4 * i), 32'd0, 5'(16 + i), 1'b1, 1'b1,
           {1'b0, 2'd2, 4'b0000, 32'h500 + 32'(4 * i)}, 32'd0);
    end
    in_valid = 1'b1; in_ld = 3'd5; in_addr = 32'h510; in_pc = 32'h5010; bus.addr_ok = 1'b1;
    @(negedge clk);
    chk("full_ready", EW'(in_ready), EW'(0));
    chk("full_req", EW'(bus.req), EW'(0));
    chk("full_valid", EW'(out_valid), EW'(0));
    tick();
    in_valid = 1'b0; in_ld = 3'd0; bus.addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) respond(32'hA0000001 + 32'(i));
    wait_drain("drain_full");

    // flush with a done head held by WB and two loads in flight
    out_ready = 1'b0;
    send(32'h6100, 3'd0, 2'd0, 32'h77, 32'd0, 5'd20, 1'b1, 1'b0, 39'd0, 32'd0);
    send(32'h6000, 3'd5, 2'd0, 32'h600, 32'd0, 5'd21, 1'b1, 1'b1, {1'b0, 2'd2, 4'b0000, 32'h600}, 32'd0);
    send(32'h6004, 3'd5, 2'd0, 32'h604, 32'd0, 5'd22, 1'b1, 1'b1, {1'b0, 2'd2, 4'b0000, 32'h604}, 32'd0);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h6200;
    @(negedge clk);
    chk("pre_flush_head", EW'(out_valid), EW'(1));
    chk("flush_ready", EW'(in_ready), EW'(0));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_flush", EW'(out_valid), EW'(0));
    tick();
    out_ready = 1'b1;
    push_exp(32'h6010, 5'd12, 1'b1, 32'h33333333);
    send(32'h6010, 3'd5, 2'd0, 32'h610, 32'd0, 5'd12, 1'b1, 1'b1, {1'b0, 2'd2, 4'b0000, 32'h610}, 32'd0);
    respond(32'h11111111);
    respond(32'h22222222);
    respond(32'h33333333);
    wait_drain("drain_flush");

    // flush coinciding with a response owed to a flushed load
    send(32'h7000, 3'd5, 2'd0, 32'h700, 32'd0, 5'd23, 1'b1, 1'b1, {1'b0, 2'd2, 4'b0000, 32'h700}, 32'd0);
    send(32'h7004, 3'd5, 2'd0, 32'h704, 32'd0, 5'd24, 1'b1, 1'b1, {1'b0, 2'd2, 4'b0000, 32'h704}, 32'd0);
    flush = 1'b1; bus.data_ok = 1'b1; bus.rdata = 32'hBAD0BAD0;
    tick();
    flush = 1'b0; bus.data_ok = 1'b0;
    push_exp(32'h7010, 5'd13, 1'b1, 32'h44444444);
    send(32'h7010, 3'd5, 2'd0, 32'h710, 32'd0, 5'd13, 1'b1, 1'b1, {1'b0, 2'd2, 4'b0000, 32'h710}, 32'd0);
    respond(32'hBAD1BAD1);
    respond(32'h44444444);
    wait_drain("drain_flush_rsp");

    // WB stall: head outputs stay put
    out_ready = 1'b0;
    push_exp(32'h8000, 5'd14, 1'b1, 32'h99);
    send(32'h8000, 3'd0, 2'd0, 32'h99, 32'd0, 5'd14, 1'b1, 1'b0, 39'd0, 32'd0);
    @(negedge clk);
    chk("stall_hold", EW'({out_valid, out_pc, out_wdata}), EW'({1'b1, 32'h8000, 32'h99}));
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("stall_hold", EW'({out_valid, out_pc, out_wdata}), EW'({1'b1, 32'h8000, 32'h99}));
    end
    tick();
    out_ready = 1'b1;
    wait_drain("drain_stall");

`ifdef MEM_ALIGN_CHK_EN
    // misaligned ld.w: no bus request, exception reported through WB
    out_ready = 1'b0;
    push_exp(32'h9000, 5'd15, 1'b0, 32'd0);
    send(32'h9000, 3'd5, 2'd0, 32'h101, 32'd0, 5'd15, 1'b1, 1'b0, 39'd0, 32'd0);
    @(negedge clk);
    chk("ale", EW'({out_valid, out_ale, out_gr_we, out_badv}), EW'({1'b1, 1'b1, 1'b0, 32'h101}));
    tick();
    out_ready = 1'b1;
    wait_drain("drain_ale");
`endif

    repeat (3) tick();
    chk("pop_total", EW'(n_pops), EW'(n_pushed));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
